// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes, FSM states
// and the size-to-byte-count helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Reserved size reports zero bytes; it is rejected by the size check anyway.
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// DEPTH x 8 storage with four independently addressed byte lanes.
// Writes land on the rising edge; reads are combinational; no backpressure.
module dmem_byte_ram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                             clk_i,
    input  logic [3:0]                       we_i,
    input  logic [3:0][$clog2(DEPTH)-1:0]    addr_i,
    input  logic [3:0][7:0]                  wdata_i,
    output logic [3:0][7:0]                  rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) begin
                mem_q[addr_i[k]] <= wdata_i[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdata_o[k] = mem_q[addr_i[k]];
        end
    end

endmodule

// File: rtl/data_memory_sync.sv
// MEM-stage data memory: byte/half/word, little-endian, LATENCY-cycle access, errors respond next cycle.
// ready_o drops while an access is in flight; a new request may be accepted in the response cycle.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            accept;
    logic [2:0]      nbytes_in;
    logic [2:0]      nbytes_q;
    logic            misalign;
    logic            out_of_range;
    logic            bad_req;
    logic            commit;
    logic [3:0]      lane_we;
    logic [3:0][AW-1:0] lane_addr;
    logic [3:0][7:0] lane_wdat;
    logic [3:0][7:0] lane_rdat;
    logic [31:0]     load_val;

    assign ready_o = (state_q != ST_BUSY);
    assign valid_o = (state_q == ST_RESP);
    assign err_o   = valid_o && err_q;
    assign rdata_o = valid_o ? rdata_q : 32'd0;

    assign accept    = req_i && ready_o;
    assign nbytes_in = bytes_of(size_i);
    assign nbytes_q  = bytes_of(size_q);

    // Full 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign misalign     = ((size_i == SZ_HALF) && addr_i[0]) ||
                          ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));
    assign out_of_range = ({1'b0, addr_i} + 33'(nbytes_in)) > 33'(DEPTH);
    assign bad_req      = misalign || (size_i == SZ_RSVD) || out_of_range;

    assign commit = (state_q == ST_BUSY) && (cnt_q == '0);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_q + AW'(k);
            lane_wdat[k] = wdata_q[8*k +: 8];
            lane_we[k]   = commit && we_q && !rst_i && (3'(k) < nbytes_q);
        end
    end

    dmem_byte_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clk_i),
        .we_i    (lane_we),
        .addr_i  (lane_addr),
        .wdata_i (lane_wdat),
        .rdata_o (lane_rdat)
    );

    always_comb begin
        load_val = 32'd0;
        case (size_q)
            SZ_BYTE: load_val = {{24{!uns_q && lane_rdat[0][7]}}, lane_rdat[0]};
            SZ_HALF: load_val = {{16{!uns_q && lane_rdat[1][7]}}, lane_rdat[1], lane_rdat[0]};
            SZ_WORD: load_val = lane_rdat;
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? 32'd0 : load_val;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                // IDLE and RESP share the accept path.
                state_d = ST_IDLE;
                if (accept) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    addr_d  = addr_i[AW-1:0];
                    wdata_d = wdata_i;
                    err_d   = bad_req;
                    rdata_d = 32'd0;
                    if (bad_req) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: two instances (1024B/LATENCY=2 and 256B/LATENCY=4)
// driven by directed steps and random traffic against a byte-array reference model.
module tb_data_memory_sync;

    localparam int unsigned D0 = 1024;
    localparam int unsigned L0 = 2;
    localparam int unsigned D1 = 256;
    localparam int unsigned L1 = 4;

    int n_assert = 0;
    int n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        req  [2];
    logic        we   [2];
    logic        uns  [2];
    logic [1:0]  sz   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        rdy  [2];
    logic        vld  [2];
    logic        err  [2];
    logic [31:0] rdat [2];

    int unsigned depth [2] = '{D0, D1};
    int          lat   [2] = '{int'(L0), int'(L1)};

    // Reference contents, byte per entry.
    logic [7:0] mm [2][1024];

    logic        bw [5];
    logic [1:0]  bs [5];
    logic        bu [5];
    logic [31:0] ba [5];
    logic [31:0] bd [5];

    data_memory_sync #(.DEPTH(D0), .LATENCY(L0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .size_i(sz[0]),
        .unsigned_i(uns[0]), .addr_i(addr[0]), .wdata_i(wdat[0]), .ready_o(rdy[0]),
        .valid_o(vld[0]), .rdata_o(rdat[0]), .err_o(err[0])
    );

    data_memory_sync #(.DEPTH(D1), .LATENCY(L1)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .size_i(sz[1]),
        .unsigned_i(uns[1]), .addr_i(addr[1]), .wdata_i(wdat[1]), .ready_o(rdy[1]),
        .valid_o(vld[1]), .rdata_o(rdat[1]), .err_o(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input int d, input logic r, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
        req[d]  = r;
        we[d]   = w;
        sz[d]   = s;
        uns[d]  = u;
        addr[d] = a;
        wdat[d] = wd;
    endtask

    task automatic put_noise(input int d, input logic r);
        put(d, r, 1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
            $urandom, $urandom);
    endtask

    // Reference: error if size reserved, misaligned, or any byte beyond DEPTH.
    task automatic model(input int d, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd);
        int     n;
        longint v;
        n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
        e  = (n == 0) || ((a % n) != 0) || (longint'(a) + n > longint'(depth[d]));
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < n; i++) mm[d][a + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(mm[d][a + i]) << (8 * i);
                if (!u && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    // Called just after the accept edge; returns at the negedge showing valid_o.
    task automatic expect_resp(input int d, input string tag, input logic e,
                               input logic [31:0] rd, input logic noise, output logic [31:0] got);
        int edges;
        edges = -1;
        got   = 32'hx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vld[d] === 1'b1) begin
                edges = i;
                break;
            end
            if (noise) put_noise(d, 1'($urandom_range(1)));
        end
        check({tag, "/lat"}, 32'(edges), 32'(e ? 0 : lat[d]));
        if (edges >= 0) begin
            got = rdat[d];
            check({tag, "/err"}, 32'(err[d]), 32'(e));
            check({tag, "/rdata"}, rdat[d], rd);
            check({tag, "/rdy"}, 32'(rdy[d]), 32'd1);
        end
    endtask

    task automatic single(input int d, input string tag, input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input logic noise, output logic [31:0] got);
        logic        e;
        logic [31:0] rd;
        model(d, w, s, u, a, wd, e, rd);
        @(negedge clk);
        put(d, 1'b1, w, s, u, a, wd);
        @(posedge clk);
        #1;
        put_noise(d, 1'b0);
        expect_resp(d, tag, e, rd, noise && !e, got);
        put_noise(d, 1'b0);
        @(negedge clk);
        check({tag, "/pulse"}, 32'(vld[d]), 32'd0);
    endtask

    // Issues bw/bs/.. [0..n-1] with req_i held high; each accept lands in the prior RESP cycle.
    task automatic b2b(input int d, input int n);
        logic        e  [5];
        logic [31:0] rd [5];
        logic [31:0] got;
        for (int k = 0; k < n; k++) model(d, bw[k], bs[k], bu[k], ba[k], bd[k], e[k], rd[k]);
        @(negedge clk);
        put(d, 1'b1, bw[0], bs[0], bu[0], ba[0], bd[0]);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k + 1 < n) put(d, 1'b1, bw[k+1], bs[k+1], bu[k+1], ba[k+1], bd[k+1]);
            else           put_noise(d, 1'b0);
            expect_resp(d, $sformatf("b2b%0d", k), e[k], rd[k], 1'b0, got);
        end
        put_noise(d, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] exp_b [4];
        logic [31:0] a;
        logic [1:0]  s;
        logic        seen;
        int          pick;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            put(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d/rdy", d), 32'(rdy[d]), 32'd1);
            check($sformatf("rst%0d/vld", d), 32'(vld[d]), 32'd0);
            check($sformatf("rst%0d/err", d), 32'(err[d]), 32'd0);
            check($sformatf("rst%0d/rdata", d), rdat[d], 32'd0);
            rst[d] = 1'b0;
        end

        // Word store / read-back and byte lanes.
        single(0, "st10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, got);
        single(0, "ld10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, got);
        check("ld10/const", got, 32'hDEADBEEF);
        exp_b = '{32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE};
        for (int i = 0; i < 4; i++) begin
            single(0, $sformatf("lb%0d", i), 1'b0, 2'b00, 1'b0, 32'h10 + i, 32'h0, 1'b0, got);
            check($sformatf("lb%0d/const", i), got, exp_b[i]);
        end
        single(0, "lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, got);
        check("lbu13/const", got, 32'h000000DE);

        // Halfword store into the upper half of a zeroed word.
        single(0, "sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, got);
        single(0, "sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF8001, 1'b0, got);
        single(0, "lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, got);
        check("lw20/const", got, 32'h80010000);
        single(0, "lh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, got);
        check("lh22/const", got, 32'hFFFF8001);
        single(0, "lhu22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, got);
        check("lhu22/const", got, 32'h00008001);

        // Error cases on the LATENCY=4 instance.
        single(1, "e_sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0, got);
        single(1, "e_sw4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h55667788, 1'b0, got);
        single(1, "e_lw3", 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 1'b0, got);
        single(1, "e_sh5", 1'b1, 2'b01, 1'b0, 32'h5, 32'hBEEF, 1'b0, got);
        single(1, "e_rsv", 1'b1, 2'b11, 1'b0, 32'h8, 32'hCAFEBABE, 1'b0, got);
        single(1, "e_end", 1'b0, 2'b10, 1'b0, D1 - 2, 32'h0, 1'b0, got);
        single(1, "e_lw4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, got);
        check("e_lw4/const", got, 32'h55667788);

        // Stall: request fields churn while busy.
        single(0, "stall", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, got);
        check("stall/const", got, 32'hDEADBEEF);
        single(1, "stall1", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, got);
        check("stall1/const", got, 32'h11223344);

        // Back-to-back with req_i held high, including an error in the chain.
        bw = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bs = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
        bu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ba = '{32'h100, 32'h100, 32'h102, 32'h101, 32'h100};
        bd = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0};
        b2b(0, 5);
        b2b(1, 5);

        // Reset on the commit edge of a store.
        single(0, "pre40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hAAAAAAAA, 1'b0, got);
        @(negedge clk);
        put(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
        @(posedge clk);
        #1;
        put_noise(0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < int'(L0); i++) begin
            @(negedge clk);
            seen |= vld[0];
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen |= vld[0];
        end
        check("abort/novalid", 32'(seen), 32'd0);
        single(0, "post40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, got);
        check("post40/const", got, 32'hAAAAAAAA);

        // Random traffic against the reference model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++)
                single(d, "fill", 1'b1, 2'b10, 1'b0, 32'h80 + 4 * i, $urandom, 1'b0, got);
            for (int i = 0; i < 2; i++)
                single(d, "fillend", 1'b1, 2'b10, 1'b0, depth[d] - 8 + 4 * i, $urandom, 1'b0, got);
            for (int i = 0; i < 60; i++) begin
                s    = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
                pick = $urandom_range(9);
                if (pick < 7)       a = 32'h80 + $urandom_range(127);
                else if (pick == 7) a = depth[d] - 8 + $urandom_range(15);
                else if (pick == 8) a = depth[d] + $urandom_range(255);
                else                a = 32'hFFFFFFFC + $urandom_range(3);
                if (pick < 7 && $urandom_range(3) != 0) begin
                    if (s == 2'b01) a[0] = 1'b0;
                    if (s == 2'b10) a[1:0] = 2'b00;
                end
                single(d, $sformatf("rnd%0d_%0d", d, i), 1'($urandom_range(1)), s,
                       1'($urandom_range(1)), a, $urandom, 1'($urandom_range(1)), got);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
